motor_bridge_driver: RTL and testbench
======================================

Name: motor_bridge_driver

Overview:
- Consumes the 4-bit motor command produced by the rover's line-following/proximity steering logic and drives two H-bridges (left, right) with PWM.
- Filters glitches on the combinationally-latched command and enforces dead-time on every direction change, so neither bridge leg pair is ever driven simultaneously.
- Sits between the steering controller and the board motor-driver pins.

Parameters:
PERIOD, 256, PWM period in clocks (counter runs 0..PERIOD-1)
CNT_W, 8, width of PWM counter and duty input (2^CNT_W >= PERIOD)
DEADTIME, 16, clocks with both bridge inputs low on any exit from a RUN state (>=1)
STABLE_CYCLES, 4, consecutive clocks cmd must hold before it is accepted (>=1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
cmd  in  4  motor command; [3:2]=left {a,b}, [1:0]=right {a,b}; 00 coast, 10 dir A, 01 dir B, 11 illegal
duty  in  CNT_W  PWM on-time in clocks per period
enable  in  1  0 forces both motors toward coast
left_a  out  1  left bridge input A
left_b  out  1  left bridge input B
right_a  out  1  right bridge input A
right_b  out  1  right bridge input B
busy  out  1  1 while either motor is in DEAD
cmd_err  out  1  one-clock pulse when an accepted cmd has either field = 11

Behaviour:
- Reset (async, immediate): all outputs 0, accepted cmd = 0000, stability counter 0, PWM counter 0, duty latch 0, both FSMs IDLE.
- Filter: cmd is registered every clock. A stability counter resets whenever the registered cmd differs from the previous sample. When it reaches STABLE_CYCLES, the value is copied into the accepted register. Shorter pulses are ignored entirely.
- cmd_err pulses in the clock the accepted register loads a value containing 11. An 11 field is treated as coast for that motor.
- Per-motor target = enable ? decoded accepted field : COAST.
- PWM: counter increments each clock and wraps PERIOD-1 -> 0.
  - duty is latched only when counter = 0.
  - pwm_on = (counter < duty_latched); duty = 0 gives always off, duty >= PERIOD gives always on.
  - A mid-period duty change takes effect at the next wrap.
- Per-motor FSM, states IDLE, RUN_A, RUN_B, DEAD:
  - IDLE: target A -> RUN_A; target B -> RUN_B; else stay. No dead-time is needed leaving IDLE.
  - RUN_A / RUN_B: target equal to the current direction -> stay. Any other target (opposite, coast, illegal, enable low) -> DEAD, with the dead counter loaded to DEADTIME.
  - DEAD: counter decrements. When it reaches 1, move to target (IDLE, RUN_A or RUN_B) evaluated in that cycle.
  - Target changes during DEAD do not restart the count. Returning to the same direction still waits the full DEADTIME.
- Outputs are registered and follow state/pwm_on by one clock:
  - RUN_A: a = pwm_on, b = 0.
  - RUN_B: a = 0, b = pwm_on.
  - IDLE / DEAD: a = b = 0.
- Invariant: {x_a, x_b} never equals 11 on any clock.
- Latency from IDLE: cmd stable from edge k -> accepted at edge k+STABLE_CYCLES -> FSM at k+STABLE_CYCLES+1 -> pins at k+STABLE_CYCLES+2.
- Latency on reversal: add DEADTIME clocks of 00 on the pins.
- busy = OR of both FSMs in DEAD, registered with the pins.
- enable low: any RUN motor goes to DEAD, then IDLE. Pins are 00 from one clock after the FSM transition. On re-enable, motors resume from IDLE per the accepted cmd.
- The two motors are independent: one may be in DEAD while the other keeps running, so a 1010->1001 change only dead-times the right motor.
- Reset mid-DEAD or mid-RUN: pins go to 0 asynchronously and the block restarts from the reset state.

Test Plan:
1. Assert rst for 3 clocks, cmd = 1010 held -> all pins 0, busy 0, cmd_err 0 throughout reset; release -> left_a/right_a start PWM at STABLE_CYCLES+2 = 6 clocks.
2. duty = 64, cmd 0000->1010 held -> left_a and right_a high for 64 of every 256 clocks; left_b = right_b = 0; busy never 1.
3. Running 1010, switch to 0101 -> all four pins 0 and busy = 1 for exactly 16 clocks; then left_b/right_b PWM at duty 64; checker confirms a&b never both 1.
4. Running 1010, cmd glitches to 0110 for 2 clocks then back to 1010 -> no change on pins, busy stays 0, no cmd_err.
5. Duty limits: duty = 0 -> pins constantly 0 in RUN; duty = 255 -> high 255 of 256 clocks; duty changed 64->128 at counter = 100 -> current period still 64, next period 128.
6. Running 1010, cmd = 1110 -> one cmd_err pulse; left goes DEAD 16 clocks then IDLE, right keeps PWM on right_a. Then async rst pulse mid-DEAD -> pins 0 immediately, FSMs IDLE.

Source files
------------

// File: rtl/motor_bridge_driver.sv
// Dual H-bridge PWM driver: debounces the steering command, generates PWM, and
// inserts dead-time on every exit from a driven direction so no leg pair shoots through.
module motor_bridge_driver #(
    parameter int PERIOD        = 256,
    parameter int CNT_W         = 8,
    parameter int DEADTIME      = 16,
    parameter int STABLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       cmd,
    input  logic [CNT_W-1:0] duty,
    input  logic             enable,
    output logic             left_a,
    output logic             left_b,
    output logic             right_a,
    output logic             right_b,
    output logic             busy,
    output logic             cmd_err
);

    localparam int SC_W = $clog2(STABLE_CYCLES + 1);
    localparam int DT_W = $clog2(DEADTIME + 1);
    localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(STABLE_CYCLES - 1);
    localparam logic [SC_W-1:0]  SC_DONE  = SC_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
    localparam logic [DT_W-1:0]  DT_LOAD  = DT_W'(DEADTIME);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN_A = 2'd1,
        RUN_B = 2'd2,
        DEAD  = 2'd3
    } state_t;

    typedef struct packed {
        state_t          st;
        logic [DT_W-1:0] cnt;
    } motor_t;

    logic [3:0]       cmd_p0;
    logic [3:0]       cmd_acc;
    logic [SC_W-1:0]  stab_cnt;
    logic [CNT_W-1:0] pwm_cnt;
    logic [CNT_W-1:0] duty_l;
    logic [CNT_W-1:0] duty_cur;
    logic             pwm_on;
    state_t           tgt_l;
    state_t           tgt_r;
    motor_t           mot_l;
    motor_t           mot_r;

    // An illegal 11 field decodes to coast, same as 00.
    function automatic state_t decode_field(input logic [1:0] f);
        state_t s;
        case (f)
            2'b10:   s = RUN_A;
            2'b01:   s = RUN_B;
            default: s = IDLE;
        endcase
        return s;
    endfunction

    function automatic logic has_illegal(input logic [3:0] c);
        return (c[3:2] == 2'b11) || (c[1:0] == 2'b11);
    endfunction

    function automatic motor_t step_motor(input motor_t m, input state_t tgt);
        motor_t n;
        n = m;
        case (m.st)
            IDLE: n.st = tgt;
            RUN_A, RUN_B: begin
                if (tgt != m.st) begin
                    n.st  = DEAD;
                    n.cnt = DT_LOAD;
                end
            end
            default: begin
                // Target is re-evaluated only on the final dead-time clock.
                if (m.cnt <= DT_W'(1)) n.st = tgt;
                else                   n.cnt = m.cnt - DT_W'(1);
            end
        endcase
        return n;
    endfunction

    function automatic logic [1:0] drive_pins(input state_t st, input logic on);
        logic [1:0] p;
        case (st)
            RUN_A:   p = {on, 1'b0};
            RUN_B:   p = {1'b0, on};
            default: p = 2'b00;
        endcase
        return p;
    endfunction

    // Stage p0: command sample and stability filter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_p0   <= 4'b0000;
            stab_cnt <= '0;
            cmd_acc  <= 4'b0000;
            cmd_err  <= 1'b0;
        end else begin
            cmd_p0  <= cmd;
            cmd_err <= 1'b0;
            if (cmd != cmd_p0) begin
                stab_cnt <= '0;
            end else if (stab_cnt != SC_DONE) begin
                stab_cnt <= stab_cnt + SC_W'(1);
                if (stab_cnt == SC_LAST) begin
                    cmd_acc <= cmd_p0;
                    cmd_err <= has_illegal(cmd_p0);
                end
            end
        end
    end

    // The new duty must already apply on the wrap clock itself, before duty_l updates.
    assign duty_cur = (pwm_cnt == '0) ? duty : duty_l;
    assign pwm_on   = pwm_cnt < duty_cur;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt <= '0;
            duty_l  <= '0;
        end else begin
            if (pwm_cnt == '0) duty_l <= duty;
            pwm_cnt <= (pwm_cnt == CNT_LAST) ? '0 : pwm_cnt + CNT_W'(1);
        end
    end

    assign tgt_l = enable ? decode_field(cmd_acc[3:2]) : IDLE;
    assign tgt_r = enable ? decode_field(cmd_acc[1:0]) : IDLE;

    // Stage p1: per-motor FSMs; pins and busy follow the current state by one clock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mot_l   <= '{st: IDLE, cnt: '0};
            mot_r   <= '{st: IDLE, cnt: '0};
            left_a  <= 1'b0;
            left_b  <= 1'b0;
            right_a <= 1'b0;
            right_b <= 1'b0;
            busy    <= 1'b0;
        end else begin
            mot_l              <= step_motor(mot_l, tgt_l);
            mot_r              <= step_motor(mot_r, tgt_r);
            {left_a, left_b}   <= drive_pins(mot_l.st, pwm_on);
            {right_a, right_b} <= drive_pins(mot_r.st, pwm_on);
            busy               <= (mot_l.st == DEAD) || (mot_r.st == DEAD);
        end
    end

endmodule

// File: tb/tb_motor_bridge_driver.sv
// Testbench for motor_bridge_driver: directed scenarios plus randomized command
// streams, all compared against a behavioural model of the bridge driver.
module tb_motor_bridge_driver;

    localparam int PERIOD   = 256;
    localparam int CNT_W    = 8;
    localparam int DEADTIME = 16;
    localparam int STABLE   = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       cmd;
    logic [CNT_W-1:0] duty;
    logic             enable;
    logic             left_a, left_b, right_a, right_b, busy, cmd_err;
    logic [5:0]       dut_out;

    int errors = 0;
    int checks = 0;

    // Reference model: motor mode 0 coast, 1 dir A, 2 dir B, 3 dead-time
    logic [3:0] m_last, m_acc;
    int         m_run, m_pcnt, m_dlat;
    int         m_mode[2];
    int         m_dleft[2];
    logic [5:0] m_out;

    motor_bridge_driver #(
        .PERIOD(PERIOD), .CNT_W(CNT_W), .DEADTIME(DEADTIME), .STABLE_CYCLES(STABLE)
    ) dut (
        .clk(clk), .rst(rst), .cmd(cmd), .duty(duty), .enable(enable),
        .left_a(left_a), .left_b(left_b), .right_a(right_a), .right_b(right_b),
        .busy(busy), .cmd_err(cmd_err)
    );

    assign dut_out = {left_a, left_b, right_a, right_b, busy, cmd_err};

    always #5 clk = ~clk;

    task automatic model_reset();
        m_last = 4'b0000; m_acc = 4'b0000; m_run = 0; m_pcnt = 0; m_dlat = 0;
        for (int m = 0; m < 2; m++) begin m_mode[m] = 0; m_dleft[m] = 0; end
        m_out = 6'b0;
    endtask

    task automatic model_step();
        int         duty_eff, tgt;
        bit         on;
        logic [1:0] fld;
        logic [5:0] o;
        duty_eff = (m_pcnt == 0) ? int'(duty) : m_dlat;
        on = (m_pcnt < duty_eff);
        o = 6'b0;
        o[5] = (m_mode[0] == 1) && on;
        o[4] = (m_mode[0] == 2) && on;
        o[3] = (m_mode[1] == 1) && on;
        o[2] = (m_mode[1] == 2) && on;
        o[1] = (m_mode[0] == 3) || (m_mode[1] == 3);
        for (int m = 0; m < 2; m++) begin
            fld = (m == 0) ? m_acc[3:2] : m_acc[1:0];
            if (!enable)             tgt = 0;
            else if (fld == 2'b10)   tgt = 1;
            else if (fld == 2'b01)   tgt = 2;
            else                     tgt = 0;
            case (m_mode[m])
                0: m_mode[m] = tgt;
                1, 2: if (tgt != m_mode[m]) begin m_mode[m] = 3; m_dleft[m] = DEADTIME; end
                default: begin
                    m_dleft[m]--;
                    if (m_dleft[m] == 0) m_mode[m] = tgt;
                end
            endcase
        end
        if (m_pcnt == 0) m_dlat = int'(duty);
        m_pcnt = (m_pcnt + 1) % PERIOD;
        if (cmd == m_last) begin
            if (m_run <= STABLE) m_run++;
        end else begin
            m_run = 0;
        end
        m_last = cmd;
        if (m_run == STABLE) begin
            m_acc = cmd;
            o[0] = (cmd[3:2] == 2'b11) || (cmd[1:0] == 2'b11);
        end
        m_out = o;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset(); else model_step();
        #1;
    endtask

    task automatic test_reset();
        int first_on;
        cmd = 4'b1010; duty = 8'd64; enable = 1'b1; rst = 1'b1; model_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (dut_out !== 6'b0) begin errors++; $display("FAIL reset_hold cyc=%0d got=%b exp=000000", i, dut_out); end
        end
        rst = 1'b0;
        first_on = -1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            checks++;
            if (dut_out !== m_out) begin errors++; $display("FAIL reset_release cyc=%0d got=%b exp=%b", i, dut_out, m_out); end
            if (left_a && right_a && first_on < 0) first_on = i;
        end
        // Edge 1 is the first sample of the held command.
        checks++;
        if (first_on !== 1 + STABLE + 2) begin errors++; $display("FAIL reset_latency got=%0d exp=%0d", first_on, 1 + STABLE + 2); end
    endtask

    task automatic test_pwm();
        int la, ra, b_any, busy_any;
        cmd = 4'b0000; duty = 8'd64;
        for (int i = 0; i < 40; i++) tick();
        cmd = 4'b1010;
        for (int i = 0; i < 20; i++) tick();
        la = 0; ra = 0; b_any = 0; busy_any = 0;
        for (int i = 0; i < PERIOD; i++) begin
            tick();
            checks++;
            if (dut_out !== m_out) begin errors++; $display("FAIL pwm64 cyc=%0d got=%b exp=%b", i, dut_out, m_out); end
            la += int'(left_a); ra += int'(right_a);
            b_any += int'(left_b | right_b); busy_any += int'(busy);
        end
        checks++;
        if (la !== 64 || ra !== 64) begin errors++; $display("FAIL pwm64_count got=%0d/%0d exp=64/64", la, ra); end
        checks++;
        if (b_any !== 0 || busy_any !== 0) begin errors++; $display("FAIL pwm64_quiet got b=%0d busy=%0d exp=0/0", b_any, busy_any); end
    endtask

    task automatic test_reverse();
        int busy_cnt, lb;
        cmd = 4'b0101; busy_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            checks++;
            if (dut_out !== m_out) begin errors++; $display("FAIL reverse cyc=%0d got=%b exp=%b", i, dut_out, m_out); end
            if (busy) begin
                busy_cnt++;
                checks++;
                if (dut_out[5:2] !== 4'b0000) begin errors++; $display("FAIL reverse_dead_pins cyc=%0d got=%b exp=0000", i, dut_out[5:2]); end
            end
            checks++;
            if ((left_a & left_b) | (right_a & right_b)) begin errors++; $display("FAIL shoot_through cyc=%0d got=%b", i, dut_out); end
        end
        checks++;
        if (busy_cnt !== DEADTIME) begin errors++; $display("FAIL reverse_busy_len got=%0d exp=%0d", busy_cnt, DEADTIME); end
        lb = 0;
        for (int i = 0; i < PERIOD; i++) begin tick(); lb += int'(left_b & right_b); end
        checks++;
        if (lb !== 64) begin errors++; $display("FAIL reverse_pwm_b got=%0d exp=64", lb); end
    endtask

    task automatic test_glitch();
        int busy_any, err_any;
        cmd = 4'b1010;
        for (int i = 0; i < 40; i++) tick();
        busy_any = 0; err_any = 0;
        cmd = 4'b0110;
        for (int i = 0; i < 32; i++) begin
            if (i == 2) cmd = 4'b1010;
            tick();
            checks++;
            if (dut_out !== m_out) begin errors++; $display("FAIL glitch cyc=%0d got=%b exp=%b", i, dut_out, m_out); end
            busy_any += int'(busy); err_any += int'(cmd_err);
        end
        checks++;
        if (busy_any !== 0 || err_any !== 0) begin errors++; $display("FAIL glitch_quiet got busy=%0d err=%0d exp=0/0", busy_any, err_any); end
    endtask

    task automatic test_duty_limits();
        int hi, waited;
        duty = 8'd0;
        for (int i = 0; i < PERIOD; i++) tick();
        hi = 0;
        for (int i = 0; i < PERIOD; i++) begin tick(); hi += int'(left_a); end
        checks++;
        if (hi !== 0) begin errors++; $display("FAIL duty0 got=%0d exp=0", hi); end
        duty = 8'd255;
        for (int i = 0; i < PERIOD; i++) tick();
        hi = 0;
        for (int i = 0; i < PERIOD; i++) begin tick(); hi += int'(left_a); end
        checks++;
        if (hi !== 255) begin errors++; $display("FAIL duty255 got=%0d exp=255", hi); end
        duty = 8'd64;
        for (int i = 0; i < PERIOD; i++) tick();
        waited = 0;
        while (m_pcnt != 100 && waited < 2 * PERIOD) begin tick(); waited++; end
        checks++;
        if (m_pcnt != 100) begin errors++; $display("FAIL duty_mid_wait got=%0d exp=100", m_pcnt); end
        duty = 8'd128;
        hi = 0;
        for (int i = 0; i < PERIOD - 100; i++) begin
            tick();
            hi += int'(left_a);
            checks++;
            if (dut_out !== m_out) begin errors++; $display("FAIL duty_mid cyc=%0d got=%b exp=%b", i, dut_out, m_out); end
        end
        checks++;
        if (hi !== 0) begin errors++; $display("FAIL duty_mid_current got=%0d exp=0", hi); end
        hi = 0;
        for (int i = 0; i < PERIOD; i++) begin tick(); hi += int'(left_a); end
        checks++;
        if (hi !== 128) begin errors++; $display("FAIL duty_mid_next got=%0d exp=128", hi); end
    endtask

    task automatic test_cmd_err();
        int err_cnt, busy_cnt, la, ra, waited;
        cmd = 4'b1010; duty = 8'd64;
        for (int i = 0; i < 30; i++) tick();
        cmd = 4'b1110; err_cnt = 0; busy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            checks++;
            if (dut_out !== m_out) begin errors++; $display("FAIL cmd_err cyc=%0d got=%b exp=%b", i, dut_out, m_out); end
            err_cnt += int'(cmd_err); busy_cnt += int'(busy);
        end
        checks++;
        if (err_cnt !== 1 || busy_cnt !== DEADTIME) begin errors++; $display("FAIL cmd_err_pulse got err=%0d busy=%0d exp=1/%0d", err_cnt, busy_cnt, DEADTIME); end
        la = 0; ra = 0;
        for (int i = 0; i < PERIOD; i++) begin tick(); la += int'(left_a | left_b); ra += int'(right_a); end
        checks++;
        if (la !== 0 || ra !== 64) begin errors++; $display("FAIL cmd_err_split got left=%0d right=%0d exp=0/64", la, ra); end
        cmd = 4'b1010;
        for (int i = 0; i < 30; i++) tick();
        waited = 0;
        while (!left_a && waited < 2 * PERIOD) begin tick(); waited++; end
        checks++;
        if (!left_a) begin errors++; $display("FAIL run_wait timeout got=%b exp=1", left_a); end
        rst = 1'b1; model_reset(); #1;
        checks++;
        if (dut_out !== 6'b0) begin errors++; $display("FAIL reset_mid_run got=%b exp=000000", dut_out); end
        tick(); tick();
        rst = 1'b0; cmd = 4'b0101;
        for (int i = 0; i < 20; i++) tick();
        cmd = 4'b1010; waited = 0;
        while (!busy && waited < 40) begin tick(); waited++; end
        checks++;
        if (!busy) begin errors++; $display("FAIL dead_wait timeout got=%b exp=1", busy); end
        tick(); tick(); tick();
        rst = 1'b1; model_reset(); #1;
        checks++;
        if (dut_out !== 6'b0) begin errors++; $display("FAIL reset_mid_dead got=%b exp=000000", dut_out); end
        tick(); tick();
        rst = 1'b0; cmd = 4'b0000;
        for (int i = 0; i < 30; i++) begin
            tick();
            checks++;
            if (dut_out !== 6'b0 || m_out !== 6'b0) begin errors++; $display("FAIL post_reset_idle cyc=%0d got=%b exp=000000", i, dut_out); end
        end
    endtask

    task automatic test_enable();
        int busy_cnt;
        cmd = 4'b1010; enable = 1'b1;
        for (int i = 0; i < 30; i++) tick();
        enable = 1'b0; busy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            checks++;
            if (dut_out !== m_out) begin errors++; $display("FAIL enable_low cyc=%0d got=%b exp=%b", i, dut_out, m_out); end
            busy_cnt += int'(busy);
        end
        checks++;
        if (busy_cnt !== DEADTIME || dut_out !== 6'b0) begin errors++; $display("FAIL enable_low_dead got busy=%0d out=%b exp=%0d/000000", busy_cnt, dut_out, DEADTIME); end
        enable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (dut_out !== m_out) begin errors++; $display("FAIL re_enable cyc=%0d got=%b exp=%b", i, dut_out, m_out); end
        end
    endtask

    task automatic test_random();
        int hold;
        for (int seg = 0; seg < 200; seg++) begin
            cmd = 4'($urandom_range(0, 15));
            hold = $urandom_range(1, 30);
            enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 5))
                    0:       duty = 8'd0;
                    1:       duty = 8'd255;
                    2:       duty = 8'd1;
                    default: duty = 8'($urandom_range(0, 255));
                endcase
            end
            for (int i = 0; i < hold; i++) begin
                tick();
                checks++;
                if (dut_out !== m_out) begin errors++; $display("FAIL random seg=%0d cyc=%0d cmd=%b got=%b exp=%b", seg, i, cmd, dut_out, m_out); end
                checks++;
                if ((left_a & left_b) | (right_a & right_b)) begin errors++; $display("FAIL random_shoot_through seg=%0d got=%b", seg, dut_out); end
            end
        end
    endtask

    initial begin
        rst = 1'b1; cmd = 4'b1010; duty = 8'd64; enable = 1'b1;
        model_reset();
        test_reset();
        test_pwm();
        test_reverse();
        test_glitch();
        test_duty_limits();
        test_cmd_err();
        test_enable();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
